// File: rtl/pilha_pkg.sv
// Shared constants and command-FSM encoding for the pilha hardware stack.
package pilha_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic {
    ESPERA = 1'b0,
    LIBERA = 1'b1
  } estado_e;

endpackage

// File: rtl/pilha_mem.sv
// Stack storage: DEPTH x WIDTH array, synchronous write, asynchronous read.
module pilha_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
  output logic [WIDTH-1:0]           rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; entries above the count are never observable,
  // and leaving it unreset lets synthesis map it to plain RAM/register-file cells.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pilha.sv
// Hardware stack: one command per strobe pulse, registered top/pop outputs,
// occupancy flags and a sticky overflow/underflow error.
module pilha
  import pilha_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clock_pilha,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     controle_pilha,
  input  logic [WIDTH-1:0]         data_pilha,
  input  logic [WIDTH-1:0]         data_ula,
  output logic [WIDTH-1:0]         topo,
  output logic [WIDTH-1:0]         dado_pop,
  output logic                     pop_valid,
  output logic [$clog2(DEPTH):0]   ocupacao,
  output logic                     vazia,
  output logic                     cheia,
  output logic                     erro
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  estado_e          state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] topo_q, topo_d;
  logic [WIDTH-1:0] dado_pop_q, dado_pop_d;
  logic             pop_valid_q, pop_valid_d;
  logic             erro_q, erro_d;

  logic             strobe;
  logic             exec;
  logic             is_empty;
  logic             is_full;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  pilha_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clock    (clock),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wdata),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  assign strobe   = clock_pilha & (push | pop);
  assign exec     = (state_q == ESPERA) & strobe;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign wdata    = controle_pilha ? data_ula : data_pilha;
  // Entry just below the current top, which becomes the new top after a pop.
  assign rd_addr  = count_q[AW-1:0] - AW'(2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ESPERA:  if (strobe)  state_d = LIBERA;
      LIBERA:  if (!strobe) state_d = ESPERA;
      default: state_d = ESPERA;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    count_d     = count_q;
    topo_d      = topo_q;
    dado_pop_d  = dado_pop_q;
    pop_valid_d = 1'b0;
    erro_d      = erro_q;
    wr_en       = 1'b0;
    wr_addr     = count_q[AW-1:0];

    if (exec) begin
      case ({push, pop})
        2'b11: begin
          if (is_empty) begin
            wr_en   = 1'b1;
            count_d = CW'(1);
            topo_d  = wdata;
            erro_d  = 1'b1;
          end else begin
            wr_en       = 1'b1;
            wr_addr     = count_q[AW-1:0] - AW'(1);
            topo_d      = wdata;
            dado_pop_d  = topo_q;
            pop_valid_d = 1'b1;
          end
        end
        2'b10: begin
          if (is_full) begin
            erro_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
            topo_d  = wdata;
          end
        end
        2'b01: begin
          if (is_empty) begin
            erro_d = 1'b1;
          end else begin
            dado_pop_d  = topo_q;
            pop_valid_d = 1'b1;
            count_d     = count_q - CW'(1);
            topo_d      = (count_q == CW'(1)) ? '0 : rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ESPERA;
      count_q     <= '0;
      topo_q      <= '0;
      dado_pop_q  <= '0;
      pop_valid_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      topo_q      <= topo_d;
      dado_pop_q  <= dado_pop_d;
      pop_valid_q <= pop_valid_d;
      erro_q      <= erro_d;
    end
  end

  assign topo      = topo_q;
  assign dado_pop  = dado_pop_q;
  assign pop_valid = pop_valid_q;
  assign ocupacao  = count_q;
  assign vazia     = is_empty;
  assign cheia     = is_full;
  assign erro      = erro_q;

endmodule

// File: tb/tb_pilha.sv
// Self-checking bench for pilha: directed scenarios plus random commands,
// compared every cycle against a queue-based stack model.
module tb_pilha;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              clock_pilha, push, pop, controle_pilha;
  logic [WIDTH-1:0]  data_pilha, data_ula;
  logic [WIDTH-1:0]  topo, dado_pop;
  logic              pop_valid, vazia, cheia, erro;
  logic [$clog2(DEPTH):0] ocupacao;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_stack [$];
  logic [WIDTH-1:0] m_dado;
  logic             m_pv;
  logic             m_erro;
  logic             m_prev_strobe;

  pilha #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .clock_pilha   (clock_pilha),
    .push          (push),
    .pop           (pop),
    .controle_pilha(controle_pilha),
    .data_pilha    (data_pilha),
    .data_ula      (data_ula),
    .topo          (topo),
    .dado_pop      (dado_pop),
    .pop_valid     (pop_valid),
    .ocupacao      (ocupacao),
    .vazia         (vazia),
    .cheia         (cheia),
    .erro          (erro)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Apply the rules of the stack to the inputs present at this edge.
  task automatic model_edge();
    logic             s;
    logic [WIDTH-1:0] w;
    if (reset) begin
      m_stack.delete();
      m_dado = '0;
      m_pv = 1'b0;
      m_erro = 1'b0;
      m_prev_strobe = 1'b0;
    end else begin
      s = clock_pilha & (push | pop);
      w = controle_pilha ? data_ula : data_pilha;
      m_pv = 1'b0;
      if (s && !m_prev_strobe) begin
        if (push && pop) begin
          if (m_stack.size() == 0) begin
            m_stack.push_back(w);
            m_erro = 1'b1;
          end else begin
            m_dado = m_stack[m_stack.size()-1];
            m_stack[m_stack.size()-1] = w;
            m_pv = 1'b1;
          end
        end else if (push) begin
          if (m_stack.size() == DEPTH) m_erro = 1'b1;
          else m_stack.push_back(w);
        end else begin
          if (m_stack.size() == 0) m_erro = 1'b1;
          else begin
            m_dado = m_stack.pop_back();
            m_pv = 1'b1;
          end
        end
      end
      m_prev_strobe = s;
    end
  endtask

  task automatic compare_all();
    int               sz;
    logic [WIDTH-1:0] exp_top;
    sz = m_stack.size();
    exp_top = (sz == 0) ? '0 : m_stack[sz-1];
    check("topo",      32'(topo),      32'(exp_top));
    check("dado_pop",  32'(dado_pop),  32'(m_dado));
    check("pop_valid", 32'(pop_valid), 32'(m_pv));
    check("ocupacao",  32'(ocupacao),  32'(sz));
    check("vazia",     32'(vazia),     32'(sz == 0));
    check("cheia",     32'(cheia),     32'(sz == DEPTH));
    check("erro",      32'(erro),      32'(m_erro));
  endtask

  task automatic step(input logic rs, input logic cp, input logic ps, input logic pp,
                      input logic ctl, input logic [WIDTH-1:0] dp, input logic [WIDTH-1:0] du);
    reset = rs; clock_pilha = cp; push = ps; pop = pp;
    controle_pilha = ctl; data_pilha = dp; data_ula = du;
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic do_push(input logic ctl, input logic [WIDTH-1:0] dp, input logic [WIDTH-1:0] du);
    step(1'b0, 1'b1, 1'b1, 1'b0, ctl, dp, du);
    idle();
  endtask

  task automatic do_pop();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    idle();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    m_dado = '0; m_pv = 1'b0; m_erro = 1'b0; m_prev_strobe = 1'b0;
    reset = 1'b1; clock_pilha = 1'b0; push = 1'b0; pop = 1'b0;
    controle_pilha = 1'b0; data_pilha = '0; data_ula = '0;

    do_reset();
    check("rst_vazia", 32'(vazia), 32'd1);
    check("rst_cheia", 32'(cheia), 32'd0);

    // Push from both sources, then pop.
    do_push(1'b0, 16'h0011, 16'hDEAD);
    do_push(1'b1, 16'hBEEF, 16'h0022);
    check("push_topo", 32'(topo), 32'h0022);
    check("push_ocup", 32'(ocupacao), 32'd2);
    check("push_vazia", 32'(vazia), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    check("pop_dado", 32'(dado_pop), 32'h0022);
    check("pop_pv_on", 32'(pop_valid), 32'd1);
    check("pop_topo", 32'(topo), 32'h0011);
    check("pop_ocup", 32'(ocupacao), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    check("pop_pv_off", 32'(pop_valid), 32'd0);
    idle();

    // Held strobe executes once.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00AA, 16'h0000);
    idle();
    check("held_ocup", 32'(ocupacao), 32'd2);
    check("held_topo", 32'(topo), 32'h00AA);

    // Overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_push(1'b0, 16'(i), 16'h0000);
    do_push(1'b0, 16'hBEEF, 16'h0000);
    check("ovf_ocup", 32'(ocupacao), 32'd16);
    check("ovf_cheia", 32'(cheia), 32'd1);
    check("ovf_topo", 32'(topo), 32'h000F);
    check("ovf_erro", 32'(erro), 32'd1);
    do_pop();
    check("ovf_pop", 32'(dado_pop), 32'h000F);

    // Replace-top on a full stack.
    do_push(1'b0, 16'h0F0F, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h5A5A);
    check("repl_pv", 32'(pop_valid), 32'd1);
    check("repl_dado", 32'(dado_pop), 32'h0F0F);
    check("repl_topo", 32'(topo), 32'h5A5A);
    idle();

    // Underflow.
    do_reset();
    do_push(1'b0, 16'h1234, 16'h0000);
    do_pop();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    check("unf_pv", 32'(pop_valid), 32'd0);
    check("unf_dado", 32'(dado_pop), 32'h1234);
    check("unf_erro", 32'(erro), 32'd1);
    idle();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h7777, 16'h0000);
    check("unf_pp_ocup", 32'(ocupacao), 32'd1);
    check("unf_pp_pv", 32'(pop_valid), 32'd0);
    idle();

    // Reset on the executing edge of a push with 3 entries, strobe kept high.
    do_reset();
    for (int i = 0; i < 3; i++) do_push(1'b0, 16'(16'h0100 + i), 16'h0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0999, 16'h0000);
    check("rmid_ocup", 32'(ocupacao), 32'd0);
    check("rmid_topo", 32'(topo), 32'h0000);
    check("rmid_erro", 32'(erro), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0ABC, 16'h0000);
    check("rmid_exec", 32'(ocupacao), 32'd1);
    idle();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 1)),
           16'($urandom), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pilha.md
PILHA -- requirements
Module: pilha

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of stack entries (power of two).
REQ-003 The block SHALL have port clock, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have port clock_pilha, input, 1, meaning the command strobe from the control unit; it is sampled as data and never used as a clock.
REQ-006 The block SHALL have port push, input, 1, meaning push request, qualified by clock_pilha.
REQ-007 The block SHALL have port pop, input, 1, meaning pop request, qualified by clock_pilha.
REQ-008 The block SHALL have port controle_pilha, input, 1, meaning push data select: 0 selects data_pilha, 1 selects data_ula.
REQ-009 The block SHALL have port data_pilha, input, WIDTH, meaning push data from memory or immediate.
REQ-010 The block SHALL have port data_ula, input, WIDTH, meaning push data from the ALU result.
REQ-011 The block SHALL have port topo, output, WIDTH, meaning the registered current top-of-stack value, 0 when empty.
REQ-012 The block SHALL have port dado_pop, output, WIDTH, meaning the registered value removed by the last accepted pop.
REQ-013 The block SHALL have port pop_valid, output, 1, meaning a one-cycle pulse marking dado_pop as updated.
REQ-014 The block SHALL have port ocupacao, output, log2(DEPTH)+1, meaning the entry count, 0..DEPTH.
REQ-015 The block SHALL have ports vazia and cheia, output, 1 each, meaning count==0 and count==DEPTH.
REQ-016 The block SHALL have port erro, output, 1, meaning a sticky overflow/underflow flag, cleared only by reset.

Function
REQ-017 The block SHALL define strobe = clock_pilha & (push | pop).
REQ-018 The command FSM SHALL have states ESPERA and LIBERA.
REQ-019 In ESPERA with strobe=1, the FSM SHALL execute exactly one command at that edge and move to LIBERA.
REQ-020 In LIBERA, the FSM SHALL ignore all requests and return to ESPERA on the first edge with strobe=0.
REQ-021 As a result, a request held high for N cycles SHALL execute once; a new command needs strobe low for at least one cycle.
REQ-022 Push only, count<DEPTH: the block SHALL write the selected word at index count, count+1, and topo=selected word on the same edge.
REQ-023 Pop only, count>0: the block SHALL set dado_pop=old top, pop_valid=1 on the next cycle only, count-1, and topo=new top, or 0 if now empty.
REQ-024 Push and pop together, count>0: the block SHALL replace the top entry: dado_pop=old top, pop_valid pulses, top entry=selected word, count unchanged; this also applies when full.
REQ-025 Push and pop together, count=0: the block SHALL perform a push only, set erro, and leave pop_valid low.
REQ-026 Push when full: the block SHALL leave stack contents and count unchanged and set erro.
REQ-027 Pop when empty: the block SHALL leave contents, count and dado_pop unchanged, set erro, and leave pop_valid low.
REQ-028 controle_pilha, data_pilha and data_ula SHALL be sampled only at the executing edge.
REQ-029 Flags vazia and cheia SHALL be decoded from the registered count and take no extra cycle.

Reset
REQ-030 With reset high at a clock edge, the block SHALL set count=0, topo=0, dado_pop=0, pop_valid=0, erro=0 and FSM=ESPERA, so vazia=1 and cheia=0.
REQ-031 Reset SHALL take priority over any simultaneous command; stack memory contents are not reset.
REQ-032 If strobe is high in the first cycle after reset release, the block SHALL execute that command once.

Structure
REQ-033 Package pilha_pkg SHALL hold default WIDTH/DEPTH constants and the FSM state encoding (ESPERA=0, LIBERA=1).
REQ-034 Storage SHALL be one sub-module pilha_mem: DEPTH x WIDTH, synchronous write, asynchronous read.
REQ-035 The pointer, FSM and flag logic SHALL reside in pilha.

Verification
REQ-036 Test push sequence: after reset, push 0x0011 (controle_pilha=0), then 0x0022 (controle_pilha=1 via data_ula) -> topo=0x0022, ocupacao=2, vazia=0.
REQ-037 Test pop: from REQ-036, pop -> dado_pop=0x0022, pop_valid is a single one-cycle pulse, topo=0x0011, ocupacao=1.
REQ-038 Test held strobe: clock_pilha=push=1 held for 5 cycles with data 0x00AA -> exactly one push, ocupacao increases by 1.
REQ-039 Test overflow: 16 pushes of 0..15, then push 0xBEEF -> ocupacao=16, cheia=1, topo=15, erro=1; then pop -> dado_pop=15.
REQ-040 Test underflow: from empty, pop -> pop_valid stays 0, dado_pop unchanged, erro=1; push+pop together -> push executes, ocupacao=1.
REQ-041 Test reset mid-operation: assert reset on the executing edge of a push with 3 entries -> ocupacao=0, topo=0, erro=0, FSM in ESPERA.
